mmio_timer_responder: RTL

Memory-mapped responder on the core's data-memory bus (cs/wr/mask/addr/data_wr -> data_rd), the slave counterpart to the load/store unit's initiator side. It implements a 64-bit prescaled machine timer with a compare register, a sticky pending flag and an interrupt output. It sits beside the data memory. The top-level muxes data_rd using the hit output.

---
 rtl/timer_pkg.sv | 38 +++
 rtl/timer_prescaler.sv | 34 +++
 rtl/mmio_timer_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared register offsets, CTRL bit indices and reset constants
//               for the memory-mapped machine timer responder.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;
    localparam logic [2:0] OFF_PRESCALE    = 3'd5;
    localparam logic [2:0] OFF_STATUS      = 3'd6;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Byte-lane merge: lanes with mask[i]=1 take new_val, the rest keep old_val.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  lane_mask
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Prescale counter; emits one tick every (prescale+1) enabled
//               cycles and restarts whenever disabled or reprogrammed.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_prescale_wr,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_pcnt;

    assign o_tick = i_en && (r_pcnt == i_prescale);

    always_ff @(posedge clk) begin
        if (rst || !i_en || i_prescale_wr) begin
            r_pcnt <= '0;
        end else if (o_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_timer_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_responder
// Description : Data-bus slave with a 64-bit prescaled machine timer, compare
//               register, sticky pending flag and interrupt output.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer_responder
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        hit,
    output logic        timer_irq
);

    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic [31:0]           r_shadow;
    logic [1:0]            r_ctrl;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_pend;

    logic [2:0] w_off;
    logic       w_rd;
    logic       w_wr;
    logic       w_tick;
    logic       w_match;
    logic       w_mtime_wr;
    logic       w_prescale_wr;
    logic       w_pend_clr;
    logic       w_unused_addr;

    assign hit           = (addr[31:5] == BASE_ADDR[31:5]);
    assign w_off         = addr[4:2];
    assign w_unused_addr = ^addr[1:0];
    assign w_rd          = cs && !wr && hit;
    assign w_wr          = cs && wr && hit && (|mask);

    assign w_mtime_wr    = w_wr && ((w_off == OFF_MTIME_LO) || (w_off == OFF_MTIME_HI));
    assign w_prescale_wr = w_wr && (w_off == OFF_PRESCALE);
    assign w_pend_clr    = w_wr && (w_off == OFF_STATUS) && mask[0] && data_wr[0];
    assign w_match       = (r_mtime >= r_mtimecmp);
    assign timer_irq     = r_pend && r_ctrl[CTRL_IE];

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk           (clk),
        .rst           (rst),
        .i_en          (r_ctrl[CTRL_EN]),
        .i_prescale    (r_prescale),
        .i_prescale_wr (w_prescale_wr),
        .o_tick        (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RST;
            r_shadow   <= '0;
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_pend     <= 1'b0;
        end else begin
            // A bus write to either half suppresses the increment for all 64 bits.
            if (w_mtime_wr) begin
                if (w_off == OFF_MTIME_LO) begin
                    r_mtime[31:0] <= merge_bytes(r_mtime[31:0], data_wr, mask);
                end else begin
                    r_mtime[63:32] <= merge_bytes(r_mtime[63:32], data_wr, mask);
                end
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr && (w_off == OFF_MTIMECMP_LO)) begin
                r_mtimecmp[31:0] <= merge_bytes(r_mtimecmp[31:0], data_wr, mask);
            end
            if (w_wr && (w_off == OFF_MTIMECMP_HI)) begin
                r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], data_wr, mask);
            end
            if (w_wr && (w_off == OFF_CTRL) && mask[0]) begin
                r_ctrl <= data_wr[1:0];
            end
            if (w_prescale_wr) begin
                r_prescale <= PRESCALE_W'(merge_bytes(32'(r_prescale), data_wr, mask));
            end

            // Reading the low half latches the high half for a coherent 64-bit read.
            if (w_rd && (w_off == OFF_MTIME_LO)) begin
                r_shadow <= r_mtime[63:32];
            end

            if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        data_rd = 32'h0;
        if (w_rd) begin
            case (w_off)
                OFF_MTIME_LO:    data_rd = r_mtime[31:0];
                OFF_MTIME_HI:    data_rd = r_shadow;
                OFF_MTIMECMP_LO: data_rd = r_mtimecmp[31:0];
                OFF_MTIMECMP_HI: data_rd = r_mtimecmp[63:32];
                OFF_CTRL:        data_rd = {30'd0, r_ctrl};
                OFF_PRESCALE:    data_rd = 32'(r_prescale);
                OFF_STATUS:      data_rd = {31'd0, r_pend};
                default:         data_rd = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire
